// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage of the ARM-subset pipeline
//
// Computes Val2 (immediate rotate, register shift or memory offset), the ALU
// result and NZCV, and the branch target. Results are registered into the
// EXE/MEM register; the architectural status register lives here.
//
// Optional feature: define FORWARDING_EN to enable the operand forwarding
// muxes; otherwise op1/fwd_rm come straight from the register file values.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   freeze                   memory stall, holds EXE/MEM and status registers
//   *_in                     decoded instruction fields from ID/EXE
//   sel_src1, sel_src2       forwarding selects (00/11 RF, 01 MEM, 10 WB)
//   mem_alu_result, wb_value forwarding sources
//   wb_en_out .. dest_out    registered EXE/MEM outputs
//   status_out               NZCV (bit 3 = N)
//   branch_taken/_address    combinational branch outputs

module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        wb_en_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        imm_in,
  input  logic        branch_in,
  input  logic        s_in,
  input  logic        carry_bit_in,
  input  logic [3:0]  exe_cmd_in,
  input  logic [3:0]  dest_in,
  input  logic [11:0] shift_operand_in,
  input  logic [23:0] signed_imm_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] val_rn_in,
  input  logic [31:0] val_rm_in,
  input  logic [1:0]  sel_src1,
  input  logic [1:0]  sel_src2,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] wb_value,
  output logic        wb_en_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] st_val_out,
  output logic [3:0]  dest_out,
  output logic [3:0]  status_out,
  output logic        branch_taken,
  output logic [31:0] branch_address
);

  logic [31:0] op1;
  logic [31:0] fwd_rm;

`ifdef FORWARDING_EN
  always_comb begin
    case (sel_src1)
      2'b01:   op1 = mem_alu_result;
      2'b10:   op1 = wb_value;
      default: op1 = val_rn_in;
    endcase
    case (sel_src2)
      2'b01:   fwd_rm = mem_alu_result;
      2'b10:   fwd_rm = wb_value;
      default: fwd_rm = val_rm_in;
    endcase
  end
`else
  // Hazard unit stalls instead of forwarding; the select inputs are dead.
  logic unused_fwd;
  assign unused_fwd = ^{sel_src1, sel_src2, mem_alu_result, wb_value};
  assign op1    = val_rn_in;
  assign fwd_rm = val_rm_in;
`endif

  // Rotates are done as a right shift of the value concatenated with itself,
  // which also makes a rotate by 0 a pass-through.
  logic [4:0]  sh_amt;
  logic [4:0]  imm_rot;
  logic [31:0] imm_val;
  logic [63:0] imm_dbl;
  logic [63:0] rm_dbl;
  logic [31:0] val2;

  assign sh_amt  = shift_operand_in[11:7];
  assign imm_rot = {shift_operand_in[11:8], 1'b0};
  assign imm_val = {24'b0, shift_operand_in[7:0]};
  assign imm_dbl = {imm_val, imm_val} >> imm_rot;
  assign rm_dbl  = {fwd_rm, fwd_rm} >> sh_amt;

  always_comb begin
    val2 = fwd_rm;
    if (mem_read_in || mem_write_in) begin
      val2 = {20'b0, shift_operand_in};
    end else if (imm_in) begin
      val2 = imm_dbl[31:0];
    end else begin
      case (shift_operand_in[6:5])
        2'b00:   val2 = fwd_rm << sh_amt;
        2'b01:   val2 = fwd_rm >> sh_amt;
        2'b10:   val2 = $signed(fwd_rm) >>> sh_amt;
        default: val2 = rm_dbl[31:0];
      endcase
    end
  end

  logic [3:0]  status_q;
  logic [32:0] sum;
  logic [31:0] alu_res;
  logic        c_new;
  logic        v_new;

  // Subtraction is op1 + ~val2 + 1 (or + C for SBC) so the carry-out of the
  // 33-bit sum is directly NOT borrow.
  always_comb begin
    sum     = '0;
    alu_res = '0;
    c_new   = status_q[1];
    v_new   = status_q[0];
    case (exe_cmd_in)
      4'b0001: alu_res = val2;
      4'b1001: alu_res = ~val2;
      4'b0010, 4'b0011: begin
        sum     = {1'b0, op1} + {1'b0, val2}
                + {32'b0, (exe_cmd_in[0] & carry_bit_in)};
        alu_res = sum[31:0];
        c_new   = sum[32];
        v_new   = (op1[31] == val2[31]) && (alu_res[31] != op1[31]);
      end
      4'b0100, 4'b0101: begin
        sum     = {1'b0, op1} + {1'b0, ~val2}
                + {32'b0, (exe_cmd_in[0] ? carry_bit_in : 1'b1)};
        alu_res = sum[31:0];
        c_new   = sum[32];
        v_new   = (op1[31] != val2[31]) && (alu_res[31] != op1[31]);
      end
      4'b0110: alu_res = op1 & val2;
      4'b0111: alu_res = op1 | val2;
      4'b1000: alu_res = op1 ^ val2;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q       <= '0;
      wb_en_out      <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
      alu_result_out <= '0;
      st_val_out     <= '0;
      dest_out       <= '0;
    end else if (!freeze) begin
      if (s_in) begin
        status_q <= {alu_res[31], (alu_res == 32'b0), c_new, v_new};
      end
      wb_en_out      <= wb_en_in;
      mem_read_out   <= mem_read_in;
      mem_write_out  <= mem_write_in;
      alu_result_out <= alu_res;
      st_val_out     <= fwd_rm;
      dest_out       <= dest_in;
    end
  end

  assign status_out     = status_q;
  assign branch_taken   = branch_in;
  assign branch_address = pc_in + {{6{signed_imm_in[23]}}, signed_imm_in, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - scoreboard bench for exe_stage with a reference model

module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst, freeze, wb_en_in, mem_read_in, mem_write_in, imm_in;
  logic        branch_in, s_in, carry_bit_in;
  logic [3:0]  exe_cmd_in, dest_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in, mem_alu_result, wb_value;
  logic [1:0]  sel_src1, sel_src2;
  logic        wb_en_out, mem_read_out, mem_write_out, branch_taken;
  logic [31:0] alu_result_out, st_val_out, branch_address;
  logic [3:0]  dest_out, status_out;

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .wb_en_in(wb_en_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .imm_in(imm_in),
    .branch_in(branch_in), .s_in(s_in), .carry_bit_in(carry_bit_in),
    .exe_cmd_in(exe_cmd_in), .dest_in(dest_in),
    .shift_operand_in(shift_operand_in), .signed_imm_in(signed_imm_in),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .sel_src1(sel_src1), .sel_src2(sel_src2),
    .mem_alu_result(mem_alu_result), .wb_value(wb_value),
    .wb_en_out(wb_en_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .alu_result_out(alu_result_out),
    .st_val_out(st_val_out), .dest_out(dest_out), .status_out(status_out),
    .branch_taken(branch_taken), .branch_address(branch_address)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wb, mr, mw;
    logic [31:0] alu, st;
    logic [3:0]  dest, nzcv;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_out = '0;
  logic [3:0] m_stat = 4'b0;
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Shift one bit position at a time; type 0 LSL, 1 LSR, 2 ASR, 3 ROR.
  function automatic logic [31:0] ref_shift(input logic [31:0] v, input int amt, input int typ);
    logic [31:0] r = v;
    for (int i = 0; i < amt; i++) begin
      case (typ)
        0:       r = r * 2;
        1:       r = r / 2;
        2:       r = {r[31], r[31:1]};
        default: r = {r[0], r[31:1]};
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
`ifdef FORWARDING_EN
    if (sel == 2'b01) return mem_alu_result;
    if (sel == 2'b10) return wb_value;
`endif
    return rf;
  endfunction

  function automatic logic ovf(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic model_step();
    logic [31:0] op1, rm, v2, r;
    logic c, v;
    longint ua, ub, sa, sb, cin;
    int ti;
    if (rst) begin
      m_out  = '0;
      m_stat = 4'b0;
      return;
    end
    if (freeze) return;
    op1 = pick(sel_src1, val_rn_in);
    rm  = pick(sel_src2, val_rm_in);
    if (mem_read_in || mem_write_in) v2 = {20'b0, shift_operand_in};
    else if (imm_in) v2 = ref_shift({24'b0, shift_operand_in[7:0]}, 2 * int'(shift_operand_in[11:8]), 3);
    else v2 = ref_shift(rm, int'(shift_operand_in[11:7]), int'(shift_operand_in[6:5]));
    ua = op1; ub = v2; ti = op1; sa = ti; ti = v2; sb = ti; cin = carry_bit_in;
    c = m_stat[1]; v = m_stat[0];
    case (exe_cmd_in)
      4'd1: r = v2;
      4'd9: r = ~v2;
      4'd2: begin r = op1 + v2; c = (ua + ub) > 64'hFFFFFFFF; v = ovf(sa + sb); end
      4'd3: begin r = op1 + v2 + cin; c = (ua + ub + cin) > 64'hFFFFFFFF; v = ovf(sa + sb + cin); end
      4'd4: begin r = op1 - v2; c = ua >= ub; v = ovf(sa - sb); end
      4'd5: begin r = op1 - v2 - (1 - cin); c = ua >= ub + (1 - cin); v = ovf(sa - sb - (1 - cin)); end
      4'd6: r = op1 & v2;
      4'd7: r = op1 | v2;
      4'd8: r = op1 ^ v2;
      default: r = 32'b0;
    endcase
    if (s_in) m_stat = {r[31], r == 32'b0, c, v};
    m_out = '{wb: wb_en_in, mr: mem_read_in, mw: mem_write_in, alu: r, st: rm,
              dest: dest_in, nzcv: m_stat};
  endtask

  // Called right after a falling edge with inputs already set.
  task automatic issue();
    logic [31:0] se;
    #1;
    se = {{8{signed_imm_in[23]}}, signed_imm_in};
    check("branch_taken", {31'b0, branch_taken}, {31'b0, branch_in});
    check("branch_address", branch_address, pc_in + se * 4);
    model_step();
    exp_q.push_back(m_out);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    {wb_en_in, mem_read_in, mem_write_in, imm_in, branch_in, s_in, carry_bit_in} = '0;
    exe_cmd_in = 4'd0; dest_in = 4'd0; shift_operand_in = 12'd0; signed_imm_in = 24'd0;
    pc_in = 32'd0; val_rn_in = 32'd0; val_rm_in = 32'd0;
    sel_src1 = 2'b00; sel_src2 = 2'b00; mem_alu_result = 32'd0; wb_value = 32'd0;
    freeze = 1'b0;
  endtask

  task automatic alu_op(input logic [3:0] cmd, input logic [31:0] rn,
                        input logic imm, input logic [11:0] sh, input logic s);
    idle_inputs();
    wb_en_in = 1'b1; exe_cmd_in = cmd; val_rn_in = rn; imm_in = imm;
    shift_operand_in = sh; s_in = s; dest_in = 4'd3;
  endtask

  // Monitor: the EXE/MEM register presents a new value after every edge.
  initial begin
    forever begin
      exp_t e, a;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{wb: wb_en_out, mr: mem_read_out, mw: mem_write_out, alu: alu_result_out,
              st: st_val_out, dest: dest_out, nzcv: status_out};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL exe_mem: got ctl=%b alu=%08h st=%08h d=%0d nzcv=%b expected ctl=%b alu=%08h st=%08h d=%0d nzcv=%b",
                   {a.wb, a.mr, a.mw}, a.alu, a.st, a.dest, a.nzcv,
                   {e.wb, e.mr, e.mw}, e.alu, e.st, e.dest, e.nzcv);
        end
      end
    end
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);

    // Reset with busy inputs.
    wb_en_in = 1'b1; mem_write_in = 1'b1; s_in = 1'b1; exe_cmd_in = 4'd2;
    val_rn_in = 32'h1234; val_rm_in = 32'h5678; dest_in = 4'd9;
    issue(); issue();
    check("reset_alu", alu_result_out, 32'd0);
    check("reset_ctl", {29'b0, wb_en_out, mem_read_out, mem_write_out}, 32'd0);
    check("reset_status", {28'b0, status_out}, 32'd0);
    rst = 1'b0;

    alu_op(4'd2, 32'd5, 1'b1, 12'h4FF, 1'b1); issue();
    check("imm_rotate", alu_result_out, 32'hFF000005);
    check("imm_rotate_nzcv", {28'b0, status_out}, 32'h8);

    alu_op(4'd4, 32'd7, 1'b1, 12'h007, 1'b1); issue();
    check("sub_zero", alu_result_out, 32'd0);
    check("sub_zero_nzcv", {28'b0, status_out}, 32'h6);
    alu_op(4'd7, 32'd1, 1'b1, 12'h002, 1'b1); issue();
    check("orr_keeps_c", {28'b0, status_out}, 32'h2);

    alu_op(4'd2, 32'h7FFFFFFF, 1'b1, 12'h001, 1'b1); issue();
    check("overflow", alu_result_out, 32'h80000000);
    check("overflow_nzcv", {28'b0, status_out}, 32'h9);

    // ASR by 31 of a negative value.
    alu_op(4'd1, 32'd0, 1'b0, {5'd31, 2'b10, 5'd0}, 1'b0); val_rm_in = 32'h80000000; issue();
    check("asr31", alu_result_out, 32'hFFFFFFFF);

    alu_op(4'd2, 32'h99, 1'b1, 12'h001, 1'b0);
    sel_src1 = 2'b01; mem_alu_result = 32'h10; issue();
`ifdef FORWARDING_EN
    check("forward", alu_result_out, 32'h11);
`else
    check("forward", alu_result_out, 32'h9A);
`endif

    // Freeze for three cycles with new operands, then release.
    alu_op(4'd2, 32'h1000, 1'b1, 12'h0AB, 1'b1); freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue();
      freeze = 1'b1;
      check("freeze_hold", alu_result_out, 32'h9A + ((`ifdef FORWARDING_EN 1 `else 0 `endif) ? -32'h89 : 32'h0));
    end
    freeze = 1'b0; issue();
    check("freeze_release", alu_result_out, 32'h10AB);

    idle_inputs(); branch_in = 1'b1; pc_in = 32'h100; signed_imm_in = 24'hFFFFFE;
    #1;
    check("branch_addr_const", branch_address, 32'hF8);
    check("branch_taken_const", {31'b0, branch_taken}, 32'd1);
    issue();
    check("bubble_ctl", {29'b0, wb_en_out, mem_read_out, mem_write_out}, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 49) == 0);
      freeze       = ($urandom_range(0, 9) == 0);
      wb_en_in     = $urandom;
      mem_read_in  = ($urandom_range(0, 7) == 0);
      mem_write_in = ($urandom_range(0, 7) == 0);
      imm_in       = $urandom;
      branch_in    = $urandom;
      s_in         = $urandom;
      carry_bit_in = $urandom;
      exe_cmd_in   = $urandom;
      dest_in      = $urandom;
      shift_operand_in = $urandom;
      signed_imm_in    = $urandom;
      pc_in        = $urandom;
      case ($urandom_range(0, 3))
        0:       val_rn_in = 32'h7FFFFFFF;
        1:       val_rn_in = 32'h80000000;
        default: val_rn_in = $urandom;
      endcase
      val_rm_in      = ($urandom_range(0, 3) == 0) ? val_rn_in : $urandom;
      sel_src1       = $urandom;
      sel_src2       = $urandom;
      mem_alu_result = $urandom;
      wb_value       = $urandom;
      issue();
    end

    rst = 1'b0; idle_inputs();
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage ARM-subset pipeline, directly downstream of the ID/EXE pipeline register. Each cycle it takes one decoded instruction and computes the second operand (Val2) and the ALU result, the NZCV status and the branch target. Results are registered into the EXE/MEM pipeline register. It owns the architectural status register and supplies the carry bit to decode.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  memory stall; holds the EXE/MEM register and the status register.
- wb_en_in, mem_read_in, mem_write_in, imm_in, branch_in, s_in, carry_bit_in  in  1 each  control fields from the ID/EXE register.
- exe_cmd_in  in  4  ALU opcode.
- dest_in  in  4  destination register index.
- shift_operand_in  in  12  shifter field of the instruction.
- signed_imm_in  in  24  branch offset field.
- pc_in, val_rn_in, val_rm_in  in  32 each  PC+4 and register-file operands.
- sel_src1, sel_src2  in  2 each  forwarding select: 00 = register file, 01 = MEM-stage ALU result, 10 = WB value, 11 = register file.
- mem_alu_result, wb_value  in  32 each  forwarding sources.
- wb_en_out, mem_read_out, mem_write_out  out  1 each  registered control.
- alu_result_out, st_val_out  out  32 each  registered ALU result and store data.
- dest_out  out  4  registered destination.
- status_out  out  4  NZCV from the status register (bit 3 = N).
- branch_taken  out  1  combinational, equal to branch_in.
- branch_address  out  32  combinational, pc_in + (sign-extended signed_imm_in << 2).

## Operation
- Forwarding muxes produce op1 (from Rn) and fwd_rm (from Rm).
- Val2 selection, in priority order:
  - mem_read_in or mem_write_in: Val2 is shift_operand_in zero-extended to 32 bits.
  - imm_in: Val2 is the 8-bit value [7:0] zero-extended and rotated right by 2×[11:8].
  - Otherwise: fwd_rm shifted by amount [11:7]. The type in [6:5] is 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 means no shift.
- ALU opcodes (exe_cmd_in):
  - 0001 MOV = Val2; 1001 MVN = ~Val2.
  - 0010 ADD = op1+Val2; 0011 ADC = op1+Val2+C.
  - 0100 SUB = op1−Val2; 0101 SBC = op1−Val2−!C.
  - 0110 AND; 0111 ORR; 1000 EOR.
  - Any other opcode gives a result of 0.
  - CMP and TST are issued as 0100 and 0110 with wb_en_in = 0. LDR and STR are issued as 0010.
- C in the opcodes above is carry_bit_in.
- Flags:
  - N = result[31]; Z = (result == 0).
  - C = 33-bit carry-out for ADD/ADC; C = NOT borrow for SUB/SBC.
  - V = signed overflow for ADD/ADC/SUB/SBC.
  - For logical ops and MOV/MVN, C and V keep their previous values.
- Status register: loads the new NZCV when s_in = 1 and freeze = 0.
- EXE/MEM register: loads when freeze = 0; st_val_out takes fwd_rm.

## Timing
- Reset (rst = 1 at a rising edge): every registered output and status_out becomes 0. rst takes precedence over freeze.
- Latency:
  - The ALU result appears on alu_result_out one cycle after the operands are presented.
  - status_out updates at the same edge.
  - branch_taken and branch_address are valid in the same cycle as the inputs.
- freeze = 1: all registers hold, including status.
- Flush: not handled here. Upstream zeroes the control inputs, so a bubble produces wb_en_out = mem_read_out = mem_write_out = 0 at the next edge.
- Shift/rotate boundaries:
  - ROR and immediate rotate by 0 pass the value unchanged.
  - ASR by 31 of a negative value gives 0xFFFFFFFF.
- ADC and SBC read carry_bit_in in the same cycle. Back-to-back flag-setting ops are forwarded by decode, not here.

## Configuration
- FORWARDING_EN defined: sel_src1 and sel_src2 drive the forwarding muxes as described above.
- FORWARDING_EN undefined:
  - op1 = val_rn_in and fwd_rm = val_rm_in.
  - sel_src1, sel_src2, mem_alu_result and wb_value are ignored.
  - The hazard unit stalls instead.

## Test plan
- Reset: drive rst for 2 cycles with non-zero inputs. Expected: all outputs 0 and status_out = 0000.
- Immediate rotate: ADD with val_rn_in = 5, imm_in = 1, shift_operand_in = 0x4FF, s_in = 1. Expected: alu_result_out = 0xFF000005 and status_out = 1000 (N=1, Z=0, C=0, V=0).
- Subtract to zero: SUB 7−7 with s_in = 1. Expected: result 0 and NZCV = 0110. A following ORR with s_in = 1 keeps C = 1.
- Signed overflow: ADD 0x7FFFFFFF + 1. Expected: 0x80000000, NZCV = 1001.
- Forwarding (FORWARDING_EN defined): sel_src1 = 01, mem_alu_result = 0x10, val_rn_in = 0x99, MOV-free ADD with Val2 = 1. Expected: 0x11. With FORWARDING_EN undefined, same stimulus gives 0x9A.
- Freeze and branch:
  - freeze = 1 with new operands: outputs hold their previous values for 3 cycles, then update one cycle after release.
  - branch_in = 1, pc_in = 0x100, signed_imm_in = 0xFFFFFE: branch_address = 0xF8 in the same cycle.
